if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined CPU: owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address. Sits upstream of ID: consumes `stall_i` from hazard detection and `flush_i`/`branch_target_i` from branch resolution, and presents a fetched instruction with its PC to decode. Optional counters report stalled and flushed cycles, so the bench reads them instead of reconstructing them from internal probes.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/sat_counter.sv | 39 +++
 rtl/if_stage.sv | 146 ++++++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU front end: data width, the
// canonical NOP encoding, the IF/ID bubble value and the fetch FSM states.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- loaded into IF/ID when the fetch address is outside imem
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Field values of an empty IF/ID slot
  localparam logic [XLEN-1:0] BUBBLE_PC    = 32'h0000_0000;
  localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic            BUBBLE_VALID = 1'b0;

  typedef enum logic [0:0] {
    IF_IDLE = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: BUBBLE_PC, instr: BUBBLE_INSTR, valid: BUBBLE_VALID};

  // Instructions are word aligned; redirect targets drop their two low bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch-stage performance counters.
// Counts one per cycle while inc_i is high and sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max_s;

  assign at_max_s = (cnt_q == {W{1'b1}});

  // Next count: advance on request unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !at_max_s) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register and drives the
// instruction-memory address. Flush (branch redirect) outranks stall, which
// outranks a normal fetch. Nothing moves while start_i is low.
// Build option: define IF_PERF_CNT_EN to implement the cycle/stall/flush
// counters; without it the counter ports read constant zero.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] stall_cnt_o,
  output logic [XLEN-1:0] flush_cnt_o,
  output logic [XLEN-1:0] cycle_cnt_o
);

  // One bit wider than the PC so a 4 GiB memory size still compares correctly
  localparam logic [XLEN:0] IMEM_LIMIT = {1'b0, 32'(IMEM_WORDS)} << 2;

  if_state_e       state_q;
  if_state_e       state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  ifid_t           ifid_q;
  ifid_t           ifid_d;
  logic            run_s;
  logic            oor_s;

  // Decide whether this edge is a working cycle. From IDLE the first fetch
  // happens on the very edge that sees start_i, so both states key off start_i.
  always_comb begin
    run_s   = 1'b0;
    state_d = state_q;
    case (state_q)
      IF_IDLE: begin
        run_s   = start_i;
        state_d = start_i ? IF_RUN : IF_IDLE;
      end
      IF_RUN: begin
        run_s   = start_i;
        state_d = start_i ? IF_RUN : IF_IDLE;
      end
      default: begin
        run_s   = 1'b0;
        state_d = IF_IDLE;
      end
    endcase
  end

  // Fetch address lies beyond the end of instruction memory
  assign oor_s = ({1'b0, pc_q} >= IMEM_LIMIT);

  // Next PC and IF/ID contents: flush beats stall beats a normal fetch
  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    if (!run_s) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else if (flush_i) begin
      pc_d   = align_word(branch_target_i);
      ifid_d = IFID_BUBBLE;
    end else if (stall_i) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else begin
      pc_d      = pc_q + 32'd4;
      ifid_d.pc = pc_q;
      if (oor_s) begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end else begin
        ifid_d.instr = imem_data_i;
        ifid_d.valid = 1'b1;
      end
    end
  end

  // FSM state, PC and IF/ID register; all outputs come straight from here
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IF_IDLE;
      pc_q    <= PC_RESET;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign pc_o         = pc_q;
  assign imem_addr_o  = pc_q;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_valid_o = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  logic cyc_inc_s;
  logic stall_inc_s;
  logic flush_inc_s;

  // A flush that coincides with a stall counts only as a flush
  assign cyc_inc_s   = run_s;
  assign flush_inc_s = run_s & flush_i;
  assign stall_inc_s = run_s & stall_i & ~flush_i;

  sat_counter #(.W(XLEN)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (cyc_inc_s),
    .cnt_o (cycle_cnt_o)
  );

  sat_counter #(.W(XLEN)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc_s),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(XLEN)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc_s),
    .cnt_o (flush_cnt_o)
  );
`else
  assign cycle_cnt_o = 32'h0000_0000;
  assign stall_cnt_o = 32'h0000_0000;
  assign flush_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a table of per-cycle vectors with
// hand-derived expectations, pushed through a scoreboard queue, plus a
// hand-written asynchronous-reset sequence. Counter expectations collapse to
// zero when IF_PERF_CNT_EN is not defined.
module tb_if_stage;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [31:0] cycle_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
  } exp_t;

  typedef struct packed {
    logic        start;
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    exp_t        e;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];
  exp_t sb[$];

  if_stage #(.PC_RESET(32'h0), .IMEM_WORDS(256)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .pc_o            (pc_o),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_valid_o    (ifid_valid_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
    .cycle_cnt_o     (cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory image: word n holds A000_0000 | n (also beyond the end, as garbage)
  function automatic logic [31:0] word(input logic [31:0] idx);
    return 32'hA000_0000 | idx;
  endfunction

  assign imem_data_i = word(imem_addr_o >> 2);

  function automatic vec_t mk(input logic st, input logic sl, input logic fl,
                              input logic [31:0] tgt, input logic [31:0] pc,
                              input logic [31:0] ipc, input logic [31:0] ins,
                              input logic vl, input logic [31:0] cyc,
                              input logic [31:0] stl, input logic [31:0] fls);
    vec_t v;
    v.start = st; v.stall = sl; v.flush = fl; v.tgt = tgt;
    v.e.pc = pc; v.e.ipc = ipc; v.e.instr = ins; v.e.valid = vl;
    v.e.cyc = cyc; v.e.stl = stl; v.e.fls = fls;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, " pc"},         pc_o,                 e.pc);
    chk({tag, " imem_addr"},  imem_addr_o,          e.pc);
    chk({tag, " ifid_pc"},    ifid_pc_o,            e.ipc);
    chk({tag, " ifid_instr"}, ifid_instr_o,         e.instr);
    chk({tag, " ifid_valid"}, {31'd0, ifid_valid_o}, {31'd0, e.valid});
    chk({tag, " cycle_cnt"},  cycle_cnt_o,          PERF ? e.cyc : 32'd0);
    chk({tag, " stall_cnt"},  stall_cnt_o,          PERF ? e.stl : 32'd0);
    chk({tag, " flush_cnt"},  flush_cnt_o,          PERF ? e.fls : 32'd0);
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare after the edge
  task automatic step(input string tag, input logic st, input logic sl,
                      input logic fl, input logic [31:0] tgt, input exp_t e);
    exp_t got;
    start_i = st; stall_i = sl; flush_i = fl; branch_target_i = tgt;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check_outs(tag, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    exp_t e;
    rst_e = '0;

    //       st sl fl tgt           pc            ipc           instr          v  cyc    stl   fls
    vecs[0]  = mk(1, 0, 0, 32'h0,        32'h4,        32'h0,        word(32'd0),   1, 32'd1,  32'd0, 32'd0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        32'h8,        32'h4,        word(32'd1),   1, 32'd2,  32'd0, 32'd0);
    vecs[2]  = mk(1, 1, 0, 32'h0,        32'h8,        32'h4,        word(32'd1),   1, 32'd3,  32'd1, 32'd0);
    vecs[3]  = mk(1, 1, 0, 32'h0,        32'h8,        32'h4,        word(32'd1),   1, 32'd4,  32'd2, 32'd0);
    vecs[4]  = mk(1, 0, 0, 32'h0,        32'hC,        32'h8,        word(32'd2),   1, 32'd5,  32'd2, 32'd0);
    vecs[5]  = mk(1, 0, 0, 32'h0,        32'h10,       32'hC,        word(32'd3),   1, 32'd6,  32'd2, 32'd0);
    vecs[6]  = mk(1, 1, 1, 32'h23,       32'h20,       32'h0,        32'h0,         0, 32'd7,  32'd2, 32'd1);
    vecs[7]  = mk(1, 0, 0, 32'h0,        32'h24,       32'h20,       word(32'd8),   1, 32'd8,  32'd2, 32'd1);
    vecs[8]  = mk(0, 0, 0, 32'h0,        32'h24,       32'h20,       word(32'd8),   1, 32'd8,  32'd2, 32'd1);
    vecs[9]  = mk(0, 1, 0, 32'h0,        32'h24,       32'h20,       word(32'd8),   1, 32'd8,  32'd2, 32'd1);
    vecs[10] = mk(0, 0, 1, 32'h100,      32'h24,       32'h20,       word(32'd8),   1, 32'd8,  32'd2, 32'd1);
    vecs[11] = mk(1, 0, 0, 32'h0,        32'h28,       32'h24,       word(32'd9),   1, 32'd9,  32'd2, 32'd1);
    vecs[12] = mk(1, 0, 1, 32'h3FE,      32'h3FC,      32'h0,        32'h0,         0, 32'd10, 32'd2, 32'd2);
    vecs[13] = mk(1, 0, 0, 32'h0,        32'h400,      32'h3FC,      word(32'd255), 1, 32'd11, 32'd2, 32'd2);
    vecs[14] = mk(1, 0, 0, 32'h0,        32'h404,      32'h400,      32'h13,        0, 32'd12, 32'd2, 32'd2);
    vecs[15] = mk(1, 1, 0, 32'h0,        32'h404,      32'h400,      32'h13,        0, 32'd13, 32'd3, 32'd2);
    vecs[16] = mk(1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,         0, 32'd14, 32'd3, 32'd3);
    vecs[17] = mk(1, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h13,        0, 32'd15, 32'd3, 32'd3);
    vecs[18] = mk(1, 0, 0, 32'h0,        32'h4,        32'h0,        word(32'd0),   1, 32'd16, 32'd3, 32'd3);

    // Reset asserted from time zero, start already high: nothing may move
    rst_i = 1'b0; start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    branch_target_i = 32'h0;
    #1;
    check_outs("reset", rst_e);
    @(posedge clk_i);
    #1;
    check_outs("reset_edge", rst_e);
    #6;
    rst_i = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("v%0d", i), vecs[i].start, vecs[i].stall, vecs[i].flush,
           vecs[i].tgt, vecs[i].e);
    end

    // One more running cycle, then pulse reset in the middle of the cycle
    e = vecs[18].e;
    e.pc = 32'h8; e.ipc = 32'h4; e.instr = word(32'd1); e.cyc = 32'd17;
    step("run_pre_rst", 1'b1, 1'b0, 1'b0, 32'h0, e);
    #2;
    rst_i = 1'b0;
    #1;
    check_outs("async_rst", rst_e);
    start_i = 1'b0;
    #1;
    rst_i = 1'b1;

    // Back in IDLE with start low: still frozen at reset values
    step("idle_hold", 1'b0, 1'b0, 1'b0, 32'h0, rst_e);

    // Start again: first fetch on the starting edge
    e = rst_e;
    e.pc = 32'h4; e.ipc = 32'h0; e.instr = word(32'd0); e.valid = 1'b1; e.cyc = 32'd1;
    step("restart", 1'b1, 1'b0, 1'b0, 32'h0, e);

    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
